l2_coherence_responder: RTL
===========================

// Module: l2_coherence_responder
// PURPOSE
//  Shared L2 responder servicing L1 read misses and write-throughs from four cores, one request at a time.
//  Direct-mapped, one 64-bit word per line, write-allocate. A per-line sharer directory drives write-update
//  broadcasts to the other L1s and invalidates for evicted lines. Backing memory sits behind a req/ack port.
// PARAMETERS
//  DATA_W   64  data word width
//  ADDR_W   32  word address width
//  INDEX_W  4   line index bits (2**INDEX_W lines)
//  NPROC    4   number of cores / sharer bits
//  PROC_W   2   core id width (clog2 NPROC)
// PORTS
//  clk        in   1        clock, all state updates on rising edge
//  rst        in   1        synchronous active-high reset
//  req_valid  in   1        request present
//  req_ready  out  1        responder can accept (IDLE only)
//  req_write  in   1        1 = write-through, 0 = read miss
//  req_proc   in   PROC_W   requesting core id
//  req_addr   in   ADDR_W   word address; index=[INDEX_W-1:0], tag=[ADDR_W-1:INDEX_W]
//  req_wdata  in   DATA_W   write data
//  rsp_valid  out  1        one-cycle completion pulse, no backpressure
//  rsp_hit    out  1        L2 hit, qualified by rsp_valid
//  rsp_data   out  DATA_W   read data (reads) / echoed write data (writes)
//  upd_valid  out  1        one-cycle write-update pulse to sharer L1s
//  upd_mask   out  NPROC    cores to update (never includes writer)
//  upd_addr   out  ADDR_W   updated address
//  upd_data   out  DATA_W   updated data
//  inv_valid  out  1        one-cycle eviction-invalidate pulse
//  inv_mask   out  NPROC    old sharers of evicted line
//  inv_addr   out  ADDR_W   evicted line address {old_tag,index}
//  mem_req    out  1        memory request, held until mem_ack
//  mem_we     out  1        1 = write, 0 = read; stable while mem_req
//  mem_addr   out  ADDR_W   memory address
//  mem_wdata  out  DATA_W   memory write data
//  mem_ack    in   1        memory done; sampled any cycle mem_req=1, including first
//  mem_rdata  in   DATA_W   read data, valid with mem_ack
// BEHAVIOUR
//  Reset: state IDLE; all line valid and sharer bits cleared; req_ready=1; all other outputs 0.
//  Reset mid-operation aborts the transaction: no rsp pulse, mem_req drops next cycle, array cleared.
//  FSM IDLE -> LOOKUP -> {RESP | MEM_RD | MEM_WR} -> RESP -> IDLE.
//  IDLE: req_ready=1; request latched on req_valid&&req_ready; next state LOOKUP.
//  LOOKUP: hit = valid[idx] && tag[idx]==req tag. On a valid miss, inv_valid pulses this cycle with the
//   old sharer mask and old address, unless that mask is 0. Invalid lines never generate inv.
//   Read hit -> RESP; read miss -> MEM_RD; any write -> MEM_WR.
//  MEM_RD: mem_req=1, mem_we=0 until mem_ack. On ack: line filled, tag set, valid=1, sharers={req_proc}.
//  MEM_WR: mem_req=1, mem_we=1, mem_wdata=wdata until mem_ack. On ack: line data=wdata, tag set, valid=1.
//   On write hit: sharers |= writer bit. On write miss: sharers = {writer}.
//  RESP (1 cycle): rsp_valid=1; rsp_hit = LOOKUP hit; rsp_data = line data.
//   Read hit: sharers |= requester bit.
//   Write hit with (old sharers & ~writer) != 0: upd_valid=1 with that mask, addr and data in this same cycle.
//  Latency accept->rsp_valid: read hit 2 cycles; miss or write 3 + mem wait cycles.
//  Outputs are registered; pulses last exactly one cycle, 0 otherwise; rsp_hit/rsp_data hold between pulses.
//  Requests arriving outside IDLE are ignored (req_ready=0); the requester must hold them.
//  A request to the same index right after an eviction sees the new line; no write buffering, strictly in order.
// TESTING
//  1 Reset, core0 read 0x10 (miss), mem_ack 2 cycles later with 0xAAAA -> mem read addr 0x10, rsp_hit=0,
//    rsp_data=0xAAAA, no inv.
//  2 Core1 read 0x10 -> rsp_valid 2 cycles after accept, rsp_hit=1, data 0xAAAA, no mem_req; sharers now 0011.
//  3 Core2 write 0x10=0x5555 -> mem write 0x10; upd_valid mask=0011, addr 0x10, data 0x5555; rsp_hit=1.
//  4 Core3 read 0x20 (same index 0, new tag) -> inv_valid mask=0111 addr 0x10 in LOOKUP, then mem read 0x20;
//    sharers=1000.
//  5 Core0 write 0x31 (invalid line) -> no inv, no upd, rsp_hit=0; next core0 read 0x31 hits with written data.
//  6 Assert rst during MEM_RD wait -> no rsp_valid, mem_req low after the edge, req_ready=1;
//    re-read of prior address misses.

Source files
------------

// File: rtl/l2_coherence_responder.sv
// -----------------------------------------------------------------------------
// l2_coherence_responder
//
// Shared L2 that services L1 read misses and write-throughs from NPROC cores,
// one request at a time. The L2 is direct-mapped with one DATA_W word per line
// and allocates on writes. A per-line sharer mask records which L1s hold the
// line. That mask drives two kinds of pulse:
//   - a write-update broadcast to the other sharers when a write hits
//   - an invalidate to the old sharers when a valid line is evicted
// Backing memory is reached through a simple req/ack port.
//
// Ports
//   clk, rst                  clock; synchronous active-high reset
//   req_valid/req_ready       request handshake (ready only while idle)
//   req_write/req_proc/
//   req_addr/req_wdata        request kind, core id, word address, write data
//   rsp_valid/rsp_hit/
//   rsp_data                  completion pulse, hit flag, read or echoed data
//   upd_valid/upd_mask/
//   upd_addr/upd_data         write-update pulse to the other sharer L1s
//   inv_valid/inv_mask/
//   inv_addr                  eviction-invalidate pulse to the old sharers
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_ack/
//   mem_rdata                 backing-memory port, request held until ack
//
// The FSM walks IDLE -> LOOKUP -> {RESP | MEM_RD | MEM_WR} -> RESP -> IDLE.
// Every output is registered. Each output is set on the clock edge that
// enters the state in which the output must be visible.
// -----------------------------------------------------------------------------
module l2_coherence_responder #(
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 32,
    parameter int INDEX_W = 4,
    parameter int NPROC   = 4,
    parameter int PROC_W  = 2
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [PROC_W-1:0] req_proc,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,

    output logic              rsp_valid,
    output logic              rsp_hit,
    output logic [DATA_W-1:0] rsp_data,

    output logic              upd_valid,
    output logic [NPROC-1:0]  upd_mask,
    output logic [ADDR_W-1:0] upd_addr,
    output logic [DATA_W-1:0] upd_data,

    output logic              inv_valid,
    output logic [NPROC-1:0]  inv_mask,
    output logic [ADDR_W-1:0] inv_addr,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int TAG_W  = ADDR_W - INDEX_W;
    localparam int NLINES = 1 << INDEX_W;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MEM_RD,
        MEM_WR,
        RESP
    } state_t;

    state_t state;

    // Line storage.
    logic [DATA_W-1:0] line_data    [NLINES];
    logic [TAG_W-1:0]  line_tag     [NLINES];
    logic [NLINES-1:0] line_valid;
    logic [NPROC-1:0]  line_sharers [NLINES];

    // Request captured at accept time, plus the lookup result for it.
    logic              cur_write;
    logic [PROC_W-1:0] cur_proc;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_wdata;
    logic              cur_hit;

    // Decode of the incoming request. It is used on the accept edge so that
    // the lookup result and any invalidate are already registered in LOOKUP.
    logic [INDEX_W-1:0] req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic               lookup_hit;
    logic               evict_valid;

    assign req_idx     = req_addr[INDEX_W-1:0];
    assign req_tag     = req_addr[ADDR_W-1:INDEX_W];
    assign lookup_hit  = line_valid[req_idx] && (line_tag[req_idx] == req_tag);
    assign evict_valid = line_valid[req_idx] && !lookup_hit;

    // Decode of the request held for the rest of the transaction.
    logic [INDEX_W-1:0] cur_idx;
    logic [TAG_W-1:0]   cur_tag;
    logic [NPROC-1:0]   cur_bit;
    logic [NPROC-1:0]   other_sharers;

    assign cur_idx       = cur_addr[INDEX_W-1:0];
    assign cur_tag       = cur_addr[ADDR_W-1:INDEX_W];
    assign cur_bit       = NPROC'(1) << cur_proc;
    assign other_sharers = line_sharers[cur_idx] & ~cur_bit;

    // NOTE: every register in this block takes a non-blocking assignment, so
    // each right-hand side reads the value from before the edge. For example,
    // the write-update mask is formed from the sharer mask as it was before
    // this edge ORs the writer into it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_hit    <= 1'b0;
            rsp_data   <= '0;
            upd_valid  <= 1'b0;
            upd_mask   <= '0;
            upd_addr   <= '0;
            upd_data   <= '0;
            inv_valid  <= 1'b0;
            inv_mask   <= '0;
            inv_addr   <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cur_write  <= 1'b0;
            cur_proc   <= '0;
            cur_addr   <= '0;
            cur_wdata  <= '0;
            cur_hit    <= 1'b0;
            // NOTE: only the valid and sharer bits are cleared. line_data and
            // line_tag are never read while valid is 0, so resetting them would
            // only add reset muxing to a RAM-like array.
            line_valid <= '0;
            for (int i = 0; i < NLINES; i++) begin
                line_sharers[i] <= '0;
            end
        end else begin
            // Pulse outputs default low and are raised only for the one cycle
            // that needs them.
            rsp_valid <= 1'b0;
            upd_valid <= 1'b0;
            inv_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cur_write <= req_write;
                        cur_proc  <= req_proc;
                        cur_addr  <= req_addr;
                        cur_wdata <= req_wdata;
                        cur_hit   <= lookup_hit;
                        req_ready <= 1'b0;
                        state     <= LOOKUP;
                        // A valid line with a different tag is evicted. Its
                        // sharers are told in the LOOKUP cycle. No pulse is
                        // sent when nobody shares the line.
                        if (evict_valid && (line_sharers[req_idx] != '0)) begin
                            inv_valid <= 1'b1;
                            inv_mask  <= line_sharers[req_idx];
                            inv_addr  <= {line_tag[req_idx], req_idx};
                        end
                    end
                end

                LOOKUP: begin
                    if (cur_write) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= cur_addr;
                        mem_wdata <= cur_wdata;
                        state     <= MEM_WR;
                    end else if (cur_hit) begin
                        rsp_valid             <= 1'b1;
                        rsp_hit               <= 1'b1;
                        rsp_data              <= line_data[cur_idx];
                        line_sharers[cur_idx] <= line_sharers[cur_idx] | cur_bit;
                        state                 <= RESP;
                    end else begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= cur_addr;
                        state    <= MEM_RD;
                    end
                end

                MEM_RD: begin
                    // mem_ack counts in the first cycle that mem_req is high.
                    if (mem_ack) begin
                        mem_req               <= 1'b0;
                        line_data[cur_idx]    <= mem_rdata;
                        line_tag[cur_idx]     <= cur_tag;
                        line_valid[cur_idx]   <= 1'b1;
                        line_sharers[cur_idx] <= cur_bit;
                        rsp_valid             <= 1'b1;
                        rsp_hit               <= 1'b0;
                        rsp_data              <= mem_rdata;
                        state                 <= RESP;
                    end
                end

                MEM_WR: begin
                    if (mem_ack) begin
                        mem_req             <= 1'b0;
                        mem_we              <= 1'b0;
                        line_data[cur_idx]  <= cur_wdata;
                        line_tag[cur_idx]   <= cur_tag;
                        line_valid[cur_idx] <= 1'b1;
                        if (cur_hit) begin
                            line_sharers[cur_idx] <= line_sharers[cur_idx] | cur_bit;
                            // Every other L1 holding the line gets the new
                            // word in the same cycle as the response.
                            if (other_sharers != '0) begin
                                upd_valid <= 1'b1;
                                upd_mask  <= other_sharers;
                                upd_addr  <= cur_addr;
                                upd_data  <= cur_wdata;
                            end
                        end else begin
                            line_sharers[cur_idx] <= cur_bit;
                        end
                        rsp_valid <= 1'b1;
                        rsp_hit   <= cur_hit;
                        rsp_data  <= cur_wdata;
                        state     <= RESP;
                    end
                end

                RESP: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end

                default: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
